// File: rtl/rs_pipe_skid.sv
// Elastic valid/ready pipeline built from DEPTH chained 2-entry skid-buffer relay stations.
// Every inter-stage signal, including ready, comes straight from a flop.
module rs_pipe_skid #(
  parameter int unsigned PAYLOAD_BITS = 32,
  parameter int unsigned DEPTH        = 2,
  parameter bit          RESET_DATA   = 1'b1,
  parameter int unsigned CNT_BITS     = $clog2(2 * DEPTH + 1)
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    din_vld,
  output logic                    din_rdy,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    dout_vld,
  input  logic                    dout_rdy,
  output logic [CNT_BITS-1:0]     occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } st_e;

  // Link k feeds station k; link DEPTH is the downstream port.
  logic [PAYLOAD_BITS-1:0] lnk_data [DEPTH+1];
  logic                    lnk_vld  [DEPTH+1];
  logic                    lnk_rdy  [DEPTH+1];
  logic [1:0]              st_cnt   [DEPTH];

  assign lnk_data[0]     = din;
  assign lnk_vld[0]      = din_vld;
  assign din_rdy         = lnk_rdy[0];
  assign dout            = lnk_data[DEPTH];
  assign dout_vld        = lnk_vld[DEPTH];
  assign lnk_rdy[DEPTH]  = dout_rdy;

  for (genvar k = 0; k < DEPTH; k++) begin : g_st
    st_e                     state;
    logic                    vld_q;
    logic                    rdy_reg;
    logic [PAYLOAD_BITS-1:0] main_q;
    logic [PAYLOAD_BITS-1:0] skid_q;
    logic                    acc;
    logic                    take;
    logic                    load_main;
    logic                    load_skid;

    assign acc  = lnk_vld[k] & rdy_reg;
    assign take = vld_q & lnk_rdy[k+1];

    assign load_main = ((state == ST_EMPTY) & acc) |
                       ((state == ST_ONE) & acc & take) |
                       ((state == ST_FULL) & take);
    assign load_skid = (state == ST_ONE) & acc & ~take;

    // Control: vld_q mirrors (state != EMPTY), rdy_reg mirrors (state != FULL) one edge ahead.
    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        state   <= ST_EMPTY;
        vld_q   <= 1'b0;
        rdy_reg <= 1'b0;
      end else begin
        rdy_reg <= 1'b1;
        unique case (state)
          ST_EMPTY: begin
            if (acc) begin
              state <= ST_ONE;
              vld_q <= 1'b1;
            end
          end
          ST_ONE: begin
            if (acc && !take) begin
              state   <= ST_FULL;
              rdy_reg <= 1'b0;
            end else if (!acc && take) begin
              state <= ST_EMPTY;
              vld_q <= 1'b0;
            end
          end
          ST_FULL: begin
            if (take) state <= ST_ONE;
            else      rdy_reg <= 1'b0;
          end
          default: begin
            state <= ST_EMPTY;
            vld_q <= 1'b0;
          end
        endcase
      end
    end

    // Payload: skid drains into main when the full station is taken.
    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        if (RESET_DATA) begin
          main_q <= '0;
          skid_q <= '0;
        end
      end else begin
        if (load_main) main_q <= (state == ST_FULL) ? skid_q : lnk_data[k];
        if (load_skid) skid_q <= lnk_data[k];
      end
    end

    assign lnk_vld[k+1]  = vld_q;
    assign lnk_data[k+1] = main_q;
    assign lnk_rdy[k]    = rdy_reg;
    assign st_cnt[k]     = (state == ST_FULL) ? 2'd2 :
                           (state == ST_ONE)  ? 2'd1 : 2'd0;
  end

  always_comb begin
    occupancy = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + CNT_BITS'(st_cnt[k]);
    end
  end

endmodule

// File: tb/tb_rs_pipe_skid.sv
// Scoreboard bench for rs_pipe_skid: DEPTH=2 main instance plus DEPTH=3/4 instances for latency/throughput.
module tb_rs_pipe_skid;

  logic ap_clk = 1'b0;
  logic ap_rst;
  always #5 ap_clk = ~ap_clk;

  logic [31:0] din_2, dout_2, din_3, dout_3, din_4, dout_4;
  logic        din_vld_2, din_rdy_2, dout_vld_2, dout_rdy_2;
  logic        din_vld_3, din_rdy_3, dout_vld_3, dout_rdy_3;
  logic        din_vld_4, din_rdy_4, dout_vld_4, dout_rdy_4;
  logic [2:0]  occ_2, occ_3;
  logic [3:0]  occ_4;

  rs_pipe_skid #(.PAYLOAD_BITS(32), .DEPTH(2)) u_d2 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .din(din_2), .din_vld(din_vld_2), .din_rdy(din_rdy_2),
    .dout(dout_2), .dout_vld(dout_vld_2), .dout_rdy(dout_rdy_2), .occupancy(occ_2));
  rs_pipe_skid #(.PAYLOAD_BITS(32), .DEPTH(3)) u_d3 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .din(din_3), .din_vld(din_vld_3), .din_rdy(din_rdy_3),
    .dout(dout_3), .dout_vld(dout_vld_3), .dout_rdy(dout_rdy_3), .occupancy(occ_3));
  rs_pipe_skid #(.PAYLOAD_BITS(32), .DEPTH(4)) u_d4 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .din(din_4), .din_vld(din_vld_4), .din_rdy(din_rdy_4),
    .dout(dout_4), .dout_vld(dout_vld_4), .dout_rdy(dout_rdy_4), .occupancy(occ_4));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Scoreboard for the DEPTH=2 instance: beats pushed on acceptance, popped on delivery.
  logic [31:0] sb_q[$];
  logic        mon_en = 1'b0;
  int          model_cnt = 0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_data;
  logic [31:0] exp_beat;

  always @(negedge ap_clk) begin
    if (mon_en) begin
      chk("occupancy_vs_model", 32'(occ_2), 32'(model_cnt));
      if (hold_pend) begin
        chk("stall_hold_vld", 32'(dout_vld_2), 32'd1);
        chk("stall_hold_data", dout_2, hold_data);
      end
      hold_pend = 1'b0;
      if (ap_rst) begin
        sb_q.delete();
        model_cnt = 0;
      end else begin
        if (dout_vld_2 && dout_rdy_2) begin
          if (sb_q.size() == 0) begin
            fail("unexpected_beat");
          end else begin
            exp_beat = sb_q.pop_front();
            chk("dout_order", dout_2, exp_beat);
            model_cnt--;
          end
        end else if (dout_vld_2) begin
          hold_pend = 1'b1;
          hold_data = dout_2;
        end
        if (din_vld_2 && din_rdy_2) begin
          sb_q.push_back(din_2);
          model_cnt++;
        end
      end
    end
  end

  int   n_acc;
  int   cyc;
  logic acc;

  initial begin
    ap_rst = 1'b1;
    din_2 = 32'hDEAD; din_vld_2 = 1'b1; dout_rdy_2 = 1'b0;
    din_3 = '0; din_vld_3 = 1'b0; dout_rdy_3 = 1'b0;
    din_4 = '0; din_vld_4 = 1'b0; dout_rdy_4 = 1'b0;

    // Reset held 3 cycles with din_vld high
    repeat (3) tick();
    chk("rst_din_rdy", 32'(din_rdy_2), 32'd0);
    chk("rst_dout_vld", 32'(dout_vld_2), 32'd0);
    chk("rst_occupancy", 32'(occ_2), 32'd0);
    chk("rst_dout", dout_2, 32'd0);
    ap_rst = 1'b0;
    din_vld_2 = 1'b0;
    mon_en = 1'b1;
    chk("rdy_before_first_edge", 32'(din_rdy_2), 32'd0);
    tick();
    chk("rdy_after_release", 32'(din_rdy_2), 32'd1);

    // Latency on DEPTH=3: visible after edge N+2, one cycle wide
    chk("d3_rdy", 32'(din_rdy_3), 32'd1);
    din_3 = 32'hA5; din_vld_3 = 1'b1; dout_rdy_3 = 1'b1;
    tick();
    din_vld_3 = 1'b0; din_3 = 32'h0;
    chk("lat_n0_vld", 32'(dout_vld_3), 32'd0);
    tick();
    chk("lat_n1_vld", 32'(dout_vld_3), 32'd0);
    tick();
    chk("lat_n2_vld", 32'(dout_vld_3), 32'd1);
    chk("lat_n2_data", dout_3, 32'hA5);
    tick();
    chk("lat_n3_vld", 32'(dout_vld_3), 32'd0);

    // Full stall on DEPTH=2: exactly 4 beats accepted
    n_acc = 0;
    din_vld_2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din_2 = 32'(n_acc + 1);
      acc = din_rdy_2;
      tick();
      if (acc) n_acc++;
    end
    chk("stall_accepted", 32'(n_acc), 32'd4);
    chk("stall_din_rdy", 32'(din_rdy_2), 32'd0);
    chk("stall_occupancy", 32'(occ_2), 32'd4);
    din_vld_2 = 1'b0;
    dout_rdy_2 = 1'b1;
    cyc = 0;
    while ((occ_2 != 0 || sb_q.size() != 0) && cyc < 30) begin
      tick();
      cyc++;
    end
    if (cyc >= 30) fail("stall_drain_timeout");

    // Throughput on DEPTH=4: 100 cycles, 97 contiguous outputs
    din_vld_4 = 1'b1; dout_rdy_4 = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      din_4 = 32'(c);
      chk("thr_din_rdy", 32'(din_rdy_4), 32'd1);
      tick();
      if (c >= 4) begin
        chk("thr_vld", 32'(dout_vld_4), 32'd1);
        chk("thr_data", dout_4, 32'(c - 3));
        chk("thr_occupancy", 32'(occ_4), 32'd4);
      end else begin
        chk("thr_fill_vld", 32'(dout_vld_4), 32'd0);
        chk("thr_fill_occupancy", 32'(occ_4), 32'(c));
      end
    end
    din_vld_4 = 1'b0;

    // Random handshakes on DEPTH=2, 10k beats
    n_acc = 0;
    cyc = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      din_vld_2 = 1'($urandom_range(0, 1));
      dout_rdy_2 = 1'($urandom_range(0, 1));
      din_2 = 32'h1000_0000 + 32'(n_acc);
      acc = din_vld_2 && din_rdy_2;
      tick();
      if (acc) n_acc++;
      cyc++;
    end
    if (n_acc < 10000) fail("random_timeout");
    din_vld_2 = 1'b0;
    dout_rdy_2 = 1'b1;
    cyc = 0;
    while ((occ_2 != 0 || sb_q.size() != 0) && cyc < 30) begin
      tick();
      cyc++;
    end
    chk("random_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("random_occupancy", 32'(occ_2), 32'd0);

    // Reset mid-stream with 3 beats held
    dout_rdy_2 = 1'b0;
    din_vld_2 = 1'b1;
    n_acc = 0;
    cyc = 0;
    while (n_acc < 3 && cyc < 20) begin
      din_2 = 32'hBEEF_0000 + 32'(n_acc);
      acc = din_rdy_2;
      tick();
      if (acc) n_acc++;
      cyc++;
    end
    din_vld_2 = 1'b0;
    chk("mid_occupancy", 32'(occ_2), 32'd3);
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    chk("mid_rst_occupancy", 32'(occ_2), 32'd0);
    chk("mid_rst_vld", 32'(dout_vld_2), 32'd0);
    chk("mid_rst_din_rdy", 32'(din_rdy_2), 32'd0);
    dout_rdy_2 = 1'b1;
    repeat (10) tick();
    chk("mid_no_stale_vld", 32'(dout_vld_2), 32'd0);
    chk("mid_din_rdy_back", 32'(din_rdy_2), 32'd1);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
